// File: rtl/taillight_seq_monitor.sv
// Receive-side checker for the six turn-signal lamp lines: tracks the legal
// 000 -> A -> AB -> ABC -> 000 sweep per side, flags faults and counts completed sweeps.
module taillight_seq_monitor #(
  parameter int STEP_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             la,
  input  logic             lb,
  input  logic             lc,
  input  logic             ra,
  input  logic             rb,
  input  logic             rc,
  output logic             busy_left,
  output logic             busy_right,
  output logic             seq_done,
  output logic             seq_dir,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             err_sticky,
  output logic [CNT_W-1:0] left_cnt,
  output logic [CNT_W-1:0] right_cnt
);

  localparam int               HC_W    = $clog2(STEP_CYCLES + 1);
  localparam logic [HC_W-1:0]  HC_MAX  = HC_W'(STEP_CYCLES);
  localparam logic [HC_W-1:0]  HC_ONE  = HC_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_SYNC = 3'd0, S_IDLE = 3'd1, S_L1 = 3'd2, S_L2 = 3'd3,
    S_L3 = 3'd4, S_R1 = 3'd5, S_R2 = 3'd6, S_R3 = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    P_ILL = 3'd0, P_OFF = 3'd1, P_L1 = 3'd2, P_L2 = 3'd3,
    P_L3 = 3'd4, P_R1 = 3'd5, P_R2 = 3'd6, P_R3 = 3'd7
  } pat_t;

  function automatic pat_t pat_of(input state_t s);
    case (s)
      S_L1:    pat_of = P_L1;
      S_L2:    pat_of = P_L2;
      S_L3:    pat_of = P_L3;
      S_R1:    pat_of = P_R1;
      S_R2:    pat_of = P_R2;
      S_R3:    pat_of = P_R3;
      default: pat_of = P_OFF;
    endcase
  endfunction

  // The only pattern that may legally follow each lit step.
  function automatic pat_t succ_of(input state_t s);
    case (s)
      S_L1:    succ_of = P_L2;
      S_L2:    succ_of = P_L3;
      S_R1:    succ_of = P_R2;
      S_R2:    succ_of = P_R3;
      S_L3:    succ_of = P_OFF;
      S_R3:    succ_of = P_OFF;
      default: succ_of = P_ILL;
    endcase
  endfunction

  function automatic state_t state_of(input pat_t p);
    case (p)
      P_L1:    state_of = S_L1;
      P_L2:    state_of = S_L2;
      P_L3:    state_of = S_L3;
      P_R1:    state_of = S_R1;
      P_R2:    state_of = S_R2;
      P_R3:    state_of = S_R3;
      default: state_of = S_IDLE;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [HC_W-1:0]  hc_q, hc_d;
  logic             busy_left_q, busy_left_d, busy_right_q, busy_right_d;
  logic             seq_done_q, seq_done_d, seq_dir_q, seq_dir_d;
  logic             err_q, err_d, err_sticky_q, err_sticky_d;
  logic [1:0]       err_code_q, err_code_d, fault_s;
  logic [CNT_W-1:0] left_cnt_q, left_cnt_d, right_cnt_q, right_cnt_d;
  pat_t             pat_s;

  // Lamp pattern decode; anything outside the six legal lit patterns and OFF is illegal.
  always_comb begin
    case ({la, lb, lc, ra, rb, rc})
      6'b000000: pat_s = P_OFF;
      6'b100000: pat_s = P_L1;
      6'b110000: pat_s = P_L2;
      6'b111000: pat_s = P_L3;
      6'b000100: pat_s = P_R1;
      6'b000110: pat_s = P_R2;
      6'b000111: pat_s = P_R3;
      default:   pat_s = P_ILL;
    endcase
  end

  // Next-state, fault classification and output computation.
  always_comb begin
    state_d      = state_q;
    hc_d         = hc_q;
    seq_done_d   = 1'b0;
    seq_dir_d    = seq_dir_q;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    err_sticky_d = err_sticky_q;
    left_cnt_d   = left_cnt_q;
    right_cnt_d  = right_cnt_q;
    fault_s      = 2'd0;
    case (state_q)
      S_SYNC: begin
        if (pat_s == P_OFF) state_d = S_IDLE;
        else                state_d = S_SYNC;
      end
      S_IDLE: begin
        if (pat_s == P_OFF) begin
          state_d = S_IDLE;
        end else if (pat_s == P_L1 || pat_s == P_R1) begin
          state_d = state_of(pat_s);
          hc_d    = HC_ONE;
        end else if (pat_s == P_ILL) begin
          fault_s = 2'd1;
        end else begin
          fault_s = 2'd2;
        end
      end
      default: begin
        if (pat_s == P_ILL) begin
          fault_s = 2'd1;
        end else if (pat_s == pat_of(state_q)) begin
          if (hc_q == HC_MAX) fault_s = 2'd3;
          else                hc_d    = hc_q + HC_ONE;
        end else if (pat_s != succ_of(state_q)) begin
          fault_s = 2'd2;
        end else if (hc_q != HC_MAX) begin
          fault_s = 2'd3;
        end else if (pat_s == P_OFF) begin
          state_d    = S_IDLE;
          hc_d       = {HC_W{1'b0}};
          seq_done_d = 1'b1;
          if (state_q == S_L3) begin
            seq_dir_d  = 1'b0;
            left_cnt_d = (left_cnt_q == CNT_MAX) ? left_cnt_q : left_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            seq_dir_d   = 1'b1;
            right_cnt_d = (right_cnt_q == CNT_MAX) ? right_cnt_q : right_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = state_of(pat_s);
          hc_d    = HC_ONE;
        end
      end
    endcase
    // A fault resynchronises: straight to IDLE if the lamps are already dark.
    if (fault_s != 2'd0) begin
      err_d        = 1'b1;
      err_code_d   = fault_s;
      err_sticky_d = 1'b1;
      hc_d         = {HC_W{1'b0}};
      state_d      = (pat_s == P_OFF) ? S_IDLE : S_SYNC;
    end else begin
      err_d        = 1'b0;
    end
    busy_left_d  = (state_d == S_L1) || (state_d == S_L2) || (state_d == S_L3);
    busy_right_d = (state_d == S_R1) || (state_d == S_R2) || (state_d == S_R3);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_SYNC;
      hc_q         <= {HC_W{1'b0}};
      busy_left_q  <= 1'b0;
      busy_right_q <= 1'b0;
      seq_done_q   <= 1'b0;
      seq_dir_q    <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'd0;
      err_sticky_q <= 1'b0;
      left_cnt_q   <= {CNT_W{1'b0}};
      right_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      hc_q         <= hc_d;
      busy_left_q  <= busy_left_d;
      busy_right_q <= busy_right_d;
      seq_done_q   <= seq_done_d;
      seq_dir_q    <= seq_dir_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      err_sticky_q <= err_sticky_d;
      left_cnt_q   <= left_cnt_d;
      right_cnt_q  <= right_cnt_d;
    end
  end

  assign busy_left  = busy_left_q;
  assign busy_right = busy_right_q;
  assign seq_done   = seq_done_q;
  assign seq_dir    = seq_dir_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign err_sticky = err_sticky_q;
  assign left_cnt   = left_cnt_q;
  assign right_cnt  = right_cnt_q;

endmodule
